// File: rtl/imm_gen.sv
// Immediate generator: extracts a 16- or 26-bit field from a datapath word,
// zero/sign-extends it, and registers the result with a valid flag.
module imm_gen #(
  parameter int DATA_W  = 32,
  parameter int SHORT_W = 16,
  parameter int LONG_W  = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] Data,
  input  logic [1:0]        ImmSel,
  output logic [DATA_W-1:0] Immout,
  output logic              Immout_valid
);

  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] r_imm;
  logic              r_valid;

  // ImmSel[1] picks the field width, ImmSel[0] picks sign extension
  always_comb begin
    w_imm = '0;
    unique case (ImmSel)
      2'b00: w_imm = {{(DATA_W-SHORT_W){1'b0}},
                      Data[SHORT_W-1:0]};
      2'b01: w_imm = {{(DATA_W-SHORT_W){Data[SHORT_W-1]}},
                      Data[SHORT_W-1:0]};
      2'b10: w_imm = {{(DATA_W-LONG_W){1'b0}},
                      Data[LONG_W-1:0]};
      2'b11: w_imm = {{(DATA_W-LONG_W){Data[LONG_W-1]}},
                      Data[LONG_W-1:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= en;
      if (en) r_imm <= w_imm;
    end
  end

  assign Immout       = r_imm;
  assign Immout_valid = r_valid;

endmodule

// File: tb/tb_imm_gen.sv
// Randomized and directed bench for imm_gen against
// an arithmetic mask-and-extend reference model.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] Data;
  logic [1:0]  ImmSel;
  logic [31:0] Immout;
  logic        Immout_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_imm;
  logic        m_vld;

  imm_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .Data         (Data),
    .ImmSel       (ImmSel),
    .Immout       (Immout),
    .Immout_valid (Immout_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_ext(
    input logic [31:0] d,
    input logic [1:0]  s
  );
    int          w;
    logic [31:0] mask;
    logic [31:0] v;
    w    = s[1] ? 26 : 16;
    mask = (32'h1 << w) - 32'h1;
    v    = d & mask;
    if (s[0] && d[w-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(
    input string       tag,
    input logic        e,
    input logic [31:0] d,
    input logic [1:0]  s
  );
    @(negedge clk);
    en = e; Data = d; ImmSel = s;
    @(posedge clk);
    if (e) begin
      m_imm = ref_ext(d, s);
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    #1;
    check({tag, "_imm"}, Immout, m_imm);
    check({tag, "_vld"}, {31'b0, Immout_valid}, {31'b0, m_vld});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; Data = '0; ImmSel = 2'b00;
    m_imm = '0; m_vld = 1'b0;
    #1;
    check("rst_imm", Immout, 32'h0);
    check("rst_vld", {31'b0, Immout_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc("idle0", 1'b0, 32'hDEADBEEF, 2'b11);
    check("idle_imm", Immout, 32'h0);
    cyc("idle1", 1'b0, 32'h12345678, 2'b01);

    // capture so outputs are nonzero, then async reset between edges
    cyc("pre", 1'b1, 32'hFFFFFFFF, 2'b11);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    m_imm = '0; m_vld = 1'b0;
    check("arst_imm", Immout, 32'h0);
    check("arst_vld", {31'b0, Immout_valid}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // back-to-back spec cases with en held high
    cyc("z16", 1'b1, 32'hFFFFFFFF, 2'b00);
    check("z16_lit", Immout, 32'h0000FFFF);
    cyc("s16a", 1'b1, 32'h0000FFFF, 2'b01);
    check("s16a_lit", Immout, 32'hFFFFFFFF);
    cyc("s16b", 1'b1, 32'hFFFF7FFF, 2'b01);
    check("s16b_lit", Immout, 32'h00007FFF);
    cyc("z26", 1'b1, 32'hFFFFFFFF, 2'b10);
    check("z26_lit", Immout, 32'h03FFFFFF);
    cyc("s26a", 1'b1, 32'h03FFFFFF, 2'b11);
    check("s26a_lit", Immout, 32'hFFFFFFFF);
    cyc("s26b", 1'b1, 32'hFDFFFFFF, 2'b11);
    check("s26b_lit", Immout, 32'h01FFFFFF);

    // drop en and change Data: hold last value
    cyc("hold0", 1'b0, 32'h00000000, 2'b00);
    check("hold_lit", Immout, 32'h01FFFFFF);
    cyc("hold1", 1'b0, 32'hA5A5A5A5, 2'b10);

    for (int i = 0; i < 300; i++) begin
      cyc("rnd", 1'($urandom_range(0, 3) != 0),
          $urandom, 2'($urandom_range(0, 3)));
    end

    // reset held across an edge with a capture pending
    cyc("pre2", 1'b1, 32'h00008000, 2'b01);
    @(negedge clk);
    en = 1'b1; Data = 32'h02000000; ImmSel = 2'b11;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    m_imm = '0; m_vld = 1'b0;
    check("mrst_imm", Immout, 32'h0);
    check("mrst_vld", {31'b0, Immout_valid}, 32'h0);
    @(negedge clk); rst_n = 1'b1; en = 1'b0;
    cyc("post", 1'b0, 32'hFFFFFFFF, 2'b11);
    cyc("post2", 1'b1, 32'h02000000, 2'b11);
    check("post2_lit", Immout, 32'hFE000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
